muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Sequencer and HI/LO register owner for the multicycle CPU's mult/div path.
- Accepts MULT/DIV/MTHI/MTLO requests from the main control FSM.
- Launches and holds operands for the external Booth multiplier and the external divider, counts their latency, and captures their Hi/Lo results into architectural HI/LO.
- Drives busy/done so the control FSM can stall, and drives hi_out/lo_out for MFHI/MFLO.

Parameters:
MUL_CYCLES, 32, iteration edges the multiplier needs after its load cycle
DIV_CYCLES, 32, iteration edges the divider needs after its load cycle
CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request strobe, sampled only in IDLE
op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
rs_data  in  32  operand A / move source
rt_data  in  32  operand B / divisor
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the op completes
div_zero  out  1  DIV attempted with rt_data==0; held until next accepted start
hi_out  out  32  architectural HI
lo_out  out  32  architectural LO
mul_a  out  32  multiplicand to multiplier, held stable for whole op
mul_b  out  32  multiplier operand, held stable for whole op
mul_reset  out  1  load/reset strobe to multiplier
mul_hi  in  32  multiplier Hi result
mul_lo  in  32  multiplier Lo result
div_a  out  32  dividend to divider, held stable
div_b  out  32  divisor to divider, held stable
div_reset  out  1  load/reset strobe to divider
div_hi  in  32  remainder
div_lo  in  32  quotient

Behaviour:
- Reset:
  - state=IDLE; hi_out=lo_out=0; busy=0; done=0; div_zero=0.
  - Operand registers=0; counter=0.
  - mul_reset=div_reset=1 while reset is high.
- mul_reset = reset OR (state==M_LAUNCH). div_reset = reset OR (state==D_LAUNCH). Both are 0 otherwise.
- Operand registers (opa, opb) load rs_data/rt_data only when start is accepted. mul_a=div_a=opa and mul_b=div_b=opb continuously. This is required because the multiplier reads A live on every iteration.
- States: IDLE, M_LAUNCH, M_RUN, D_LAUNCH, D_RUN, CAPTURE, FINISH.
- IDLE, start=1:
  - div_zero is cleared.
  - op=00 -> M_LAUNCH.
  - op=01 with rt_data!=0 -> D_LAUNCH.
  - op=01 with rt_data==0 -> FINISH with div_zero=1; HI/LO unchanged.
  - op=10 -> hi_out<=rs_data, go to FINISH.
  - op=11 -> lo_out<=rs_data, go to FINISH.
- M_LAUNCH / D_LAUNCH: one cycle with the load strobe high; counter<=0. Next state M_RUN / D_RUN.
- M_RUN: counter increments each cycle. When counter==MUL_CYCLES-1 -> CAPTURE. D_RUN is the same using DIV_CYCLES.
- CAPTURE:
  - hi_out<=mul_hi, lo_out<=mul_lo for a MULT; div_hi/div_lo for a DIV. The source is selected by a registered op flag.
  - Next state FINISH.
- FINISH: done=1 for exactly this cycle; next state IDLE. busy is high here and drops with done in the same transition.
- Latency is counted from the edge that samples start to the first cycle with done=1:
  - MULT = MUL_CYCLES+3 edges (35 at default).
  - DIV = DIV_CYCLES+3 edges.
  - MTHI/MTLO/div-by-zero = 1 edge.
- start while busy: ignored. Operands, op and state are untouched, and no queueing.
- start in the FINISH cycle: ignored. A new op is accepted only in IDLE.
- Reset mid-operation: returns to IDLE on the next edge. HI/LO return to 0, no done pulse, and the external units are re-strobed.
- hi_out/lo_out change only in CAPTURE or on MTHI/MTLO acceptance; they are stable during RUN. MFHI reads during busy return the old HI.
- Signedness: HI/LO hold whatever the units produce; no extension or width change in this block.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3):
  - mul_reset pulses once, 1 edge after start.
  - done appears 35 edges after start, with hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
  - busy is high for 35 cycles.
- MULT rs=0x80000000, rt=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000. mul_a/mul_b stay constant for the entire operation.
- DIV rs=100, rt=0 -> done 1 edge after start, div_zero=1, HI/LO unchanged. The next accepted start clears div_zero.
- MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678 -> hi_out=0xDEADBEEF, lo_out=0x12345678. Each op gives done 1 edge after start.
- During MULT: re-pulse start with op=11 at cycle 10 -> ignored. lo_out is the multiplication result, not rs_data, and exactly one done pulse occurs.
- reset asserted at cycle 20 of a MULT:
  - Next cycle: IDLE, hi_out=lo_out=0, busy=0, no done.
  - A subsequent MULT 5*6 yields lo_out=30, hi_out=0.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer for the external multiplier/divider and owner of architectural HI/LO.
// MULT/DIV take UNIT_CYCLES+3 edges from the accepting edge to done; MTHI/MTLO/div-by-zero take 1 edge.
module muldiv_hilo_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_reset,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_reset,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_M_LAUNCH,
    S_M_RUN,
    S_D_LAUNCH,
    S_D_RUN,
    S_CAPTURE,
    S_FINISH
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              dz_q, dz_d;
  logic              is_div_q, is_div_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    is_div_d = is_div_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d     = 1'b0;
          opa_d    = rs_data;
          opb_d    = rt_data;
          is_div_d = (op == OP_DIV);
          case (op)
            OP_MULT: state_d = S_M_LAUNCH;
            OP_DIV: begin
              if (rt_data != 32'd0) begin
                state_d = S_D_LAUNCH;
              end else begin
                dz_d    = 1'b1;
                state_d = S_FINISH;
              end
            end
            OP_MTHI: begin
              hi_d    = rs_data;
              state_d = S_FINISH;
            end
            default: begin
              lo_d    = rs_data;
              state_d = S_FINISH;
            end
          endcase
        end
      end
      S_M_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_M_RUN;
      end
      S_M_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) state_d = S_CAPTURE;
      end
      S_D_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_D_RUN;
      end
      S_D_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        hi_d    = is_div_q ? div_hi : mul_hi;
        lo_d    = is_div_q ? div_lo : mul_lo;
        state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operands stay live on the unit inputs: the multiplier re-reads A every iteration.
  assign mul_a     = opa_q;
  assign mul_b     = opb_q;
  assign div_a     = opa_q;
  assign div_b     = opb_q;
  assign mul_reset = reset | (state_q == S_M_LAUNCH);
  assign div_reset = reset | (state_q == S_D_LAUNCH);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign div_zero  = dz_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: models the external units and checks HI/LO, timing and strobes.
module tb_muldiv_hilo_ctrl;

  localparam int MUL_N = 32;
  localparam int DIV_N = 32;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_zero, mul_reset, div_reset;
  logic [31:0] hi_out, lo_out, mul_a, mul_b, div_a, div_b;
  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_dz = 1'b0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out),
    .mul_a(mul_a), .mul_b(mul_b), .mul_reset(mul_reset),
    .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_a(div_a), .div_b(div_b), .div_reset(div_reset),
    .div_hi(div_hi), .div_lo(div_lo)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // {remainder, quotient}, signed, truncating toward zero
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (b == 32'd0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Unit models only present a valid result once they have iterated long enough after their strobe.
  int mul_cnt = 0, div_cnt = 0;
  always @(posedge clk) begin
    if (mul_reset) mul_cnt <= 0; else if (mul_cnt < 1000) mul_cnt <= mul_cnt + 1;
    if (div_reset) div_cnt <= 0; else if (div_cnt < 1000) div_cnt <= div_cnt + 1;
  end

  always_comb begin
    logic [63:0] p, d;
    p = smul(mul_a, mul_b);
    d = sdiv(div_a, div_b);
    mul_hi = (mul_cnt >= MUL_N) ? p[63:32] : ~p[63:32];
    mul_lo = (mul_cnt >= MUL_N) ? p[31:0]  : ~p[31:0];
    div_hi = (div_cnt >= DIV_N) ? d[63:32] : ~d[63:32];
    div_lo = (div_cnt >= DIV_N) ? d[31:0]  : ~d[31:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt, input int inj);
    int lat, exp_lat, mr, dr, mr_first, dr_first;
    logic [63:0] r;
    logic [31:0] nh, nl;
    logic ndz;
    nh = exp_hi; nl = exp_lo; ndz = 1'b0; exp_lat = 1;
    case (o)
      2'b00: begin r = smul(rs, rt); nh = r[63:32]; nl = r[31:0]; exp_lat = MUL_N + 3; end
      2'b01: begin
        if (rt == 32'd0) ndz = 1'b1;
        else begin r = sdiv(rs, rt); nh = r[63:32]; nl = r[31:0]; exp_lat = DIV_N + 3; end
      end
      2'b10: nh = rs;
      default: nl = rs;
    endcase

    @(negedge clk);
    start = 1'b1; op = o; rs_data = rs; rt_data = rt;
    @(posedge clk); #1;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    lat = 1; mr = 0; dr = 0; mr_first = 0; dr_first = 0;
    check("dz_at_accept", div_zero, ndz);
    while (done !== 1'b1 && lat < 200) begin
      if (mul_reset) begin mr++; if (mr_first == 0) mr_first = lat; end
      if (div_reset) begin dr++; if (dr_first == 0) dr_first = lat; end
      check("busy_run", busy, 1'b1);
      check("hi_stable", hi_out, exp_hi);
      check("lo_stable", lo_out, exp_lo);
      check("mul_a_hold", mul_a, rs);
      check("mul_b_hold", mul_b, rt);
      check("div_a_hold", div_a, rs);
      check("div_b_hold", div_b, rt);
      if (lat == inj) begin start = 1'b1; op = 2'b11; rs_data = $urandom; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (mul_reset) mr++;
    if (div_reset) dr++;
    check("latency", lat, exp_lat);
    check("done_pulse", done, 1'b1);
    check("busy_finish", busy, 1'b1);
    check("hi_result", hi_out, nh);
    check("lo_result", lo_out, nl);
    check("div_zero", div_zero, ndz);
    check("mul_strobes", mr, (o == 2'b00) ? 1 : 0);
    check("div_strobes", dr, (o == 2'b01 && rt != 0) ? 1 : 0);
    if (o == 2'b00) check("mul_strobe_when", mr_first, 1);
    if (o == 2'b01 && rt != 0) check("div_strobe_when", dr_first, 1);
    @(posedge clk); #1;
    check("done_drop", done, 1'b0);
    check("busy_drop", busy, 1'b0);
    check("dz_held", div_zero, ndz);
    exp_hi = nh; exp_lo = nl; exp_dz = ndz;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_mul_reset", mul_reset, 1'b1);
    check("rst_div_reset", div_reset, 1'b1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_mul_reset", mul_reset, 1'b0);
    check("idle_div_reset", div_reset, 1'b0);

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(2'b01, 32'd100, 32'd0, -1);
    run_op(2'b10, 32'hDEAD_BEEF, 32'd0, -1);
    run_op(2'b11, 32'h1234_5678, 32'd0, -1);
    run_op(2'b01, 32'd100, 32'd7, -1);
    run_op(2'b01, 32'hFFFF_FF9C, 32'd7, -1);
    run_op(2'b00, 32'd123456, 32'd654321, 10);

    // Reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd99; rt_data = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_hi", hi_out, 32'd0);
    check("mid_rst_lo", lo_out, 32'd0);
    check("mid_rst_mul_reset", mul_reset, 1'b1);
    check("mid_rst_div_reset", div_reset, 1'b1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", done, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    run_op(2'b00, 32'd5, 32'd6, -1);

    for (int i = 0; i < 20; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(ro, ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
